// File: rtl/image_streamer.sv
// Streams a region of the image buffer onto the layers image bus under val/rdy flow control.
// Optional feature: define IMG_STREAMER_REPEAT_EN to stream the region REP+1 times per START.
module image_streamer #(
  parameter int CFG_DWIDTH = 32,
  parameter int CFG_AWIDTH = 5,
  parameter int GROUP_NB   = 4,
  parameter int IMG_WIDTH  = 16,
  parameter int BUF_AWIDTH = 12
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [CFG_DWIDTH-1:0]         cfg_data,
  input  logic [CFG_AWIDTH-1:0]         cfg_addr,
  input  logic                          cfg_valid,
  output logic                          buf_rd_en,
  output logic [BUF_AWIDTH-1:0]         buf_rd_addr,
  input  logic [GROUP_NB*IMG_WIDTH-1:0] buf_rd_data,
  output logic [GROUP_NB*IMG_WIDTH-1:0] image_bus,
  output logic                          image_last,
  output logic                          image_val,
  input  logic                          image_rdy,
  output logic                          busy,
  output logic                          done
);
  localparam int DW = GROUP_NB * IMG_WIDTH;
  localparam int CW = BUF_AWIDTH + 1;
  localparam logic [CFG_AWIDTH-1:0] ADDR_BASE  = CFG_AWIDTH'(8'h10);
  localparam logic [CFG_AWIDTH-1:0] ADDR_LEN   = CFG_AWIDTH'(8'h11);
  localparam logic [CFG_AWIDTH-1:0] ADDR_START = CFG_AWIDTH'(8'h12);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DRAIN = 2'd2} state_t;

  state_t                state_q, state_d;
  logic [BUF_AWIDTH-1:0] base_q, len_dummy_unused_s;
  logic [CW-1:0]         len_q;
  logic [BUF_AWIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         rd_cnt_q, rd_cnt_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  inflight_q, inflight_last_q;
  logic [DW-1:0]         fifo_data_q [2];
  logic [1:0]            fifo_last_q;
  logic                  fifo_wr_q, fifo_rd_q;
  logic [1:0]            fifo_cnt_q;
  logic                  start_s, pop_s, rd_en_s, unused_s;
  logic [2:0]            occ_s;
`ifdef IMG_STREAMER_REPEAT_EN
  logic [BUF_AWIDTH-1:0] act_base_q, act_base_d;
  logic [CW-1:0]         act_len_q, act_len_d;
  logic [15:0]           rep_q, rep_d;
`endif

  assign unused_s           = ^cfg_data;
  assign len_dummy_unused_s = base_q;
  assign start_s = cfg_valid && (cfg_addr == ADDR_START);
  assign pop_s   = (fifo_cnt_q != 2'd0) && image_rdy;
  // Occupancy counts the slot freed by this cycle's pop so a full-rate stream keeps one read in flight.
  assign occ_s   = {1'b0, fifo_cnt_q} + {2'b00, inflight_q} - {2'b00, pop_s};
  assign rd_en_s = (state_q == S_RUN) && (rd_cnt_q != CW'(0)) && (occ_s < 3'd2);

  // Configuration register file
  always_ff @(posedge clk) begin
    if (!rst) begin
      base_q <= '0;
      len_q  <= '0;
    end else if (cfg_valid) begin
      if (cfg_addr == ADDR_BASE) begin
        base_q <= cfg_data[BUF_AWIDTH-1:0];
      end else if (cfg_addr == ADDR_LEN) begin
        len_q <= cfg_data[CW-1:0];
      end
    end
  end

  // Control state register
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      rd_ptr_q <= '0;
      rd_cnt_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef IMG_STREAMER_REPEAT_EN
      act_base_q <= '0;
      act_len_q  <= '0;
      rep_q      <= '0;
`endif
    end else begin
      state_q  <= state_d;
      rd_ptr_q <= rd_ptr_d;
      rd_cnt_q <= rd_cnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
`ifdef IMG_STREAMER_REPEAT_EN
      act_base_q <= act_base_d;
      act_len_q  <= act_len_d;
      rep_q      <= rep_d;
`endif
    end
  end

  // Next-state logic: start decode, read sequencing and drain completion
  always_comb begin
    state_d  = state_q;
    rd_ptr_d = rd_ptr_q;
    rd_cnt_d = rd_cnt_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
`ifdef IMG_STREAMER_REPEAT_EN
    act_base_d = act_base_q;
    act_len_d  = act_len_q;
    rep_d      = rep_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start_s && (len_q != CW'(0))) begin
          state_d  = S_RUN;
          rd_ptr_d = base_q;
          rd_cnt_d = len_q;
          busy_d   = 1'b1;
`ifdef IMG_STREAMER_REPEAT_EN
          act_base_d = base_q;
          act_len_d  = len_q;
          rep_d      = cfg_data[15:0];
`endif
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        if (rd_en_s) begin
          rd_ptr_d = rd_ptr_q + BUF_AWIDTH'(1);
          rd_cnt_d = rd_cnt_q - CW'(1);
          if (rd_cnt_q == CW'(1)) begin
`ifdef IMG_STREAMER_REPEAT_EN
            if (rep_q != 16'd0) begin
              rd_ptr_d = act_base_q;
              rd_cnt_d = act_len_q;
              rep_d    = rep_q - 16'd1;
            end else begin
              state_d = S_DRAIN;
            end
`else
            state_d = S_DRAIN;
`endif
          end else begin
            state_d = S_RUN;
          end
        end else begin
          state_d = S_RUN;
        end
      end
      S_DRAIN: begin
        // The final beat is the only thing left once nothing is in flight and one entry remains.
        if (pop_s && (fifo_cnt_q == 2'd1) && !inflight_q) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          state_d = S_DRAIN;
        end
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // Read-latency tracking and two-entry output FIFO
  always_ff @(posedge clk) begin
    if (!rst) begin
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      fifo_data_q[0]  <= '0;
      fifo_data_q[1]  <= '0;
      fifo_last_q     <= 2'b00;
      fifo_wr_q       <= 1'b0;
      fifo_rd_q       <= 1'b0;
      fifo_cnt_q      <= 2'd0;
    end else begin
      inflight_q      <= rd_en_s;
      inflight_last_q <= rd_en_s && (rd_cnt_q == CW'(1));
      if (inflight_q) begin
        fifo_data_q[fifo_wr_q] <= buf_rd_data;
        fifo_last_q[fifo_wr_q] <= inflight_last_q;
        fifo_wr_q              <= ~fifo_wr_q;
      end
      if (pop_s) begin
        fifo_rd_q <= ~fifo_rd_q;
      end
      fifo_cnt_q <= fifo_cnt_q + {1'b0, inflight_q} - {1'b0, pop_s};
    end
  end

  assign buf_rd_en   = rd_en_s;
  assign buf_rd_addr = rd_ptr_q;
  assign image_val   = (fifo_cnt_q != 2'd0);
  assign image_bus   = fifo_data_q[fifo_rd_q];
  assign image_last  = fifo_last_q[fifo_rd_q];
  assign busy        = busy_q;
  assign done        = done_q;
endmodule

// File: tb/tb_image_streamer.sv
// Self-checking bench for image_streamer: directed and randomized regions against a queue-based reference.
module tb_image_streamer;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] cfg_data;
  logic [4:0]  cfg_addr;
  logic        cfg_valid;
  logic        buf_rd_en;
  logic [11:0] buf_rd_addr;
  logic [63:0] buf_rd_data;
  logic [63:0] image_bus;
  logic        image_last, image_val, image_rdy, busy, done;
  logic [63:0] mem [4096];
  int          checks = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  image_streamer dut (
    .clk(clk), .rst(rst), .cfg_data(cfg_data), .cfg_addr(cfg_addr), .cfg_valid(cfg_valid),
    .buf_rd_en(buf_rd_en), .buf_rd_addr(buf_rd_addr), .buf_rd_data(buf_rd_data),
    .image_bus(image_bus), .image_last(image_last), .image_val(image_val),
    .image_rdy(image_rdy), .busy(busy), .done(done)
  );

  // Image buffer: one-cycle synchronous read
  always @(posedge clk) begin
    if (buf_rd_en) buf_rd_data <= mem[buf_rd_addr];
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cfg_write(input logic [4:0] addr, input int data);
    cfg_valid = 1'b1;
    cfg_addr  = addr;
    cfg_data  = 32'(data);
    @(negedge clk);
    cfg_valid = 1'b0;
  endtask

  // Programs a region, starts it, and checks every beat against the expected sequence.
  task automatic run_region(input int base, input int len, input int rep, input int mode,
                            input bit disturb, input int abort_at);
    logic [64:0] expq[$];
    logic [64:0] e;
    logic [63:0] pbus;
    logic        plast;
    int npass, nbeats, c, first_c, popped;
    bit stalled, finished, rdy;
    npass = 1;
`ifdef IMG_STREAMER_REPEAT_EN
    npass = rep + 1;
`endif
    for (int p = 0; p < npass; p++)
      for (int k = 0; k < len; k++)
        expq.push_back({(k == len - 1), mem[(base + k) % 4096]});
    nbeats = expq.size();
    c = 0; first_c = -1; popped = 0; stalled = 0; finished = 0;
    pbus = '0; plast = 1'b0;
    cfg_write(5'h10, base);
    cfg_write(5'h11, len);
    cfg_write(5'h12, rep);
    while (!finished && c < 400) begin
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = ((c % 4) == 0) || ((c % 4) == 3);
        default: rdy = ($urandom_range(0, 3) != 0);
      endcase
      image_rdy = rdy;
      if (disturb) begin
        if (c == 3) begin cfg_valid = 1'b1; cfg_addr = 5'h12; cfg_data = 32'd0; end
        else if (c == 4) begin cfg_addr = 5'h10; cfg_data = 32'(base + 7); end
        else if (c == 5) begin cfg_addr = 5'h11; cfg_data = 32'(len + 1); end
        else cfg_valid = 1'b0;
      end
      if (abort_at != 0 && popped == abort_at) begin
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        chk("abort_val", {63'd0, image_val}, 64'd0);
        chk("abort_busy", {63'd0, busy}, 64'd0);
        chk("abort_rd_en", {63'd0, buf_rd_en}, 64'd0);
        repeat (6) begin
          @(negedge clk);
          chk("abort_quiet", {61'd0, busy, done, image_val}, 64'd0);
        end
        return;
      end
      if (done === 1'b1) begin
        chk("done_remaining", 64'(expq.size()), 64'd0);
        chk("done_busy", {63'd0, busy}, 64'd0);
        chk("done_val", {63'd0, image_val}, 64'd0);
        if (mode == 0) begin
          chk("first_val_cycle", 64'(first_c), 64'd2);
          chk("done_cycle", 64'(c), 64'(2 + nbeats));
        end
        @(negedge clk);
        chk("done_pulse", {61'd0, done, image_val, busy}, 64'd0);
        finished = 1;
      end else begin
        chk("busy", {63'd0, busy}, 64'd1);
        if (stalled) begin
          chk("stall_val", {63'd0, image_val}, 64'd1);
          chk("stall_bus", image_bus, pbus);
          chk("stall_last", {63'd0, image_last}, {63'd0, plast});
        end
        if (image_val === 1'b1 && first_c < 0) first_c = c;
        if (image_val === 1'b1 && rdy) begin
          if (expq.size() == 0) begin
            chk("extra_beat_val", {63'd0, image_val}, 64'd0);
          end else begin
            e = expq.pop_front();
            chk("beat_data", image_bus, e[63:0]);
            chk("beat_last", {63'd0, image_last}, {63'd0, e[64]});
            popped++;
          end
        end
        stalled = (image_val === 1'b1) && !rdy;
        pbus    = image_bus;
        plast   = image_last;
        @(negedge clk);
        c++;
      end
    end
    cfg_valid = 1'b0;
    if (!finished) chk("timeout_done", {63'd0, done}, 64'd1);
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = {32'($urandom()), 20'($urandom()), 12'(i)};
    rst = 1'b0; cfg_valid = 1'b0; cfg_addr = 5'd0; cfg_data = 32'd0; image_rdy = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {58'd0, image_val, image_last, busy, done, buf_rd_en, 1'b0}, 64'd0);
    chk("reset_bus", image_bus, 64'd0);
    rst = 1'b1;
    @(negedge clk);

    run_region(0, 4, 0, 0, 1'b0, 0);
    run_region(0, 3, 0, 1, 1'b0, 0);
    run_region(12'hFFE, 4, 0, 0, 1'b0, 0);

    cfg_write(5'h11, 0);
    cfg_write(5'h12, 0);
    repeat (4) begin
      chk("len0_ignored", {60'd0, busy, done, image_val, buf_rd_en}, 64'd0);
      @(negedge clk);
    end

    run_region(40, 6, 0, 0, 1'b1, 0);
    run_region(100, 8, 0, 0, 1'b0, 2);
    cfg_write(5'h12, 0);
    chk("post_reset_len_cleared", {62'd0, busy, image_val}, 64'd0);
    run_region(200, 5, 0, 0, 1'b0, 0);
    run_region(5, 5, 3, 0, 1'b0, 0);
`ifdef IMG_STREAMER_REPEAT_EN
    run_region(0, 2, 2, 0, 1'b0, 0);
    run_region(4094, 1, 2, 1, 1'b0, 0);
`endif
    for (int r = 0; r < 6; r++)
      run_region(int'($urandom_range(0, 4095)), int'($urandom_range(1, 12)),
                 int'($urandom_range(0, 2)), 2, 1'b0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
